tmds_channel_rx: RTL and testbench

Receive-side TMDS channel decoder for the DVI path: takes the 10-bit parallel words of one TMDS lane from a 1:10 deserializer, finds the word boundary from control-token runs during blanking, and decodes 10b back to 8-bit pixel data plus the two control bits. One instance per lane, clocked by the recovered pixel clock. It is the counterpart of the transmit-side TMDS encoder in `dvi_top`.

---
 rtl/tmds_channel_rx.sv | 152 +++++++++++++++
 tb/tb_tmds_channel_rx.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_rx.sv
// TMDS receive lane: word alignment from control-token runs, then 10b->8b decode.
// Stage 1 registers the aligned word and its token match. Stage 2 registers the gated outputs.
module tmds_channel_rx #(
    parameter int unsigned CTRL_RUN   = 8,
    parameter int unsigned SEARCH_LEN = 1024
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [9:0] tmds_i,
    output logic [7:0] data_o,
    output logic       de_o,
    output logic [1:0] ctrl_o,
    output logic       locked_o,
    output logic [3:0] offset_o
);

    localparam int unsigned RUN_W = $clog2(CTRL_RUN + 1);
    localparam int unsigned WIN_W = (SEARCH_LEN > 2) ? $clog2(SEARCH_LEN) : 1;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(CTRL_RUN);
    localparam logic [WIN_W-1:0] WIN_MAX = WIN_W'(SEARCH_LEN - 1);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t           state, state_next;
    logic [9:0]       prev;
    logic [9:0]       aw;
    logic             is_ctrl;
    logic [1:0]       pair;
    logic [9:0]       s1_aw;
    logic             s1_ctrl;
    logic [1:0]       s1_pair;
    logic [7:0]       q, d;
    logic [RUN_W-1:0] run_cnt, run_next, run_inc;
    logic [WIN_W-1:0] win_cnt, win_next;
    logic [3:0]       offset_next;
    logic             run_hit, timeout, advance, settle;
    logic [7:0]       data_n;
    logic             de_n;
    logic [1:0]       ctrl_n;

    // Bit 0 is the oldest bit, so the previous word sits below the current one.
    always_comb begin
        aw      = 10'({tmds_i, prev} >> offset_o);
        is_ctrl = 1'b1;
        pair    = 2'b00;
        case (aw)
            10'b1101010100: pair = 2'b00;
            10'b0010101011: pair = 2'b01;
            10'b0101010100: pair = 2'b10;
            10'b1010101011: pair = 2'b11;
            default:        is_ctrl = 1'b0;
        endcase
    end

    always_comb begin
        q    = s1_aw[9] ? ~s1_aw[7:0] : s1_aw[7:0];
        d    = '0;
        d[0] = q[0];
        for (int unsigned i = 1; i < 8; i++)
            d[i] = s1_aw[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end

    // A completed run takes priority over a window timeout in either state.
    always_comb begin
        run_inc     = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + 1'b1;
        run_hit     = s1_ctrl && (run_inc == RUN_MAX);
        timeout     = (win_cnt == WIN_MAX);
        state_next  = state;
        run_next    = s1_ctrl ? run_inc : '0;
        win_next    = win_cnt + 1'b1;
        offset_next = offset_o;
        advance     = 1'b0;
        if (settle) begin
            run_next = '0;
            win_next = '0;
        end else begin
            case (state)
                SEARCH: begin
                    if (run_hit) begin
                        state_next = LOCKED;
                        win_next   = '0;
                    end else if (timeout) begin
                        advance = 1'b1;
                    end
                end
                LOCKED: begin
                    if (run_hit) begin
                        win_next = '0;
                    end else if (timeout) begin
                        state_next = SEARCH;
                        advance    = 1'b1;
                    end
                end
                default: state_next = SEARCH;
            endcase
        end
        if (advance) begin
            offset_next = (offset_o == 4'd9) ? 4'd0 : offset_o + 4'd1;
            run_next    = '0;
            win_next    = '0;
        end
    end

    // Gated on the next state so outputs drop on the same edge as locked_o.
    always_comb begin
        data_n = '0;
        de_n   = 1'b0;
        ctrl_n = '0;
        if (state_next == LOCKED) begin
            if (s1_ctrl) begin
                ctrl_n = s1_pair;
            end else begin
                de_n   = 1'b1;
                data_n = d;
                ctrl_n = ctrl_o;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev     <= '0;
            s1_aw    <= '0;
            s1_ctrl  <= 1'b0;
            s1_pair  <= '0;
            state    <= SEARCH;
            run_cnt  <= '0;
            win_cnt  <= '0;
            settle   <= 1'b0;
            offset_o <= '0;
            data_o   <= '0;
            de_o     <= 1'b0;
            ctrl_o   <= '0;
        end else begin
            prev     <= tmds_i;
            s1_aw    <= aw;
            s1_ctrl  <= is_ctrl;
            s1_pair  <= pair;
            state    <= state_next;
            run_cnt  <= run_next;
            win_cnt  <= win_next;
            settle   <= advance;
            offset_o <= offset_next;
            data_o   <= data_n;
            de_o     <= de_n;
            ctrl_o   <= ctrl_n;
        end
    end

    assign locked_o = (state == LOCKED);

endmodule

// File: tb/tb_tmds_channel_rx.sv
// Directed bench for tmds_channel_rx: serial-shift stream model, data scoreboard, offset watcher.
module tb_tmds_channel_rx;

    localparam int unsigned CTRL_RUN   = 8;
    localparam int unsigned SEARCH_LEN = 16;

    localparam logic [9:0] TOK0 = 10'h354;
    localparam logic [9:0] TOK1 = 10'h0AB;
    localparam logic [9:0] TOK2 = 10'h154;
    localparam logic [9:0] TOK3 = 10'h2AB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] tmds = '0;
    logic [7:0] data_o;
    logic       de_o;
    logic [1:0] ctrl_o;
    logic       locked_o;
    logic [3:0] offset_o;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [7:0]  sb[$];
    bit          bitq[$];
    int unsigned off_last = 0;
    int unsigned off_steps = 0;

    // Hand-encoded words and the bytes they decode to.
    logic [9:0] dat_w [7] = '{10'h136, 10'h205, 10'h100, 10'h3FF, 10'h0FF, 10'h1FF, 10'h163};
    logic [7:0] dat_b [7] = '{8'h5A, 8'hF0, 8'h00, 8'h00, 8'hFF, 8'h01, 8'hA5};

    always #5 clk = ~clk;

    tmds_channel_rx #(.CTRL_RUN(CTRL_RUN), .SEARCH_LEN(SEARCH_LEN)) dut (
        .clk_i(clk), .rst_i(rst), .tmds_i(tmds), .data_o(data_o), .de_o(de_o),
        .ctrl_o(ctrl_o), .locked_o(locked_o), .offset_o(offset_o)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_shift(input int unsigned s);
        bitq.delete();
        repeat (s) bitq.push_back(1'b0);
    endtask

    // Serialise one transmit word, deserialise one receive word, run one clock.
    task automatic tx(input logic [9:0] w);
        logic [9:0] r;
        for (int j = 0; j < 10; j++) bitq.push_back(w[j]);
        for (int j = 0; j < 10; j++) r[j] = bitq.pop_front();
        tmds = r;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_data(input int unsigned idx, input bit push);
        if (push) sb.push_back(dat_b[idx]);
        tx(dat_w[idx]);
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_data", 16'(data_o), 16'h0);
        check("rst_de", 16'(de_o), 16'h0);
        check("rst_ctrl", 16'(ctrl_o), 16'h0);
        check("rst_locked", 16'(locked_o), 16'h0);
        check("rst_offset", 16'(offset_o), 16'h0);
        off_last  = 0;
        off_steps = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic aligned_lock();
        set_shift(0);
        for (int i = 0; i < 9; i++) tx(TOK0);
        check("lock_early", 16'(locked_o), 16'h0);
        tx(TOK0);
        check("lock_at_run", 16'(locked_o), 16'h1);
        check("lock_ctrl", 16'(ctrl_o), 16'h0);
        check("lock_de", 16'(de_o), 16'h0);
        check("lock_offset", 16'(offset_o), 16'h0);
        repeat (10) tx(TOK0);
        sb.push_back(8'h5A);
        tx(10'h136);
        tx(TOK0);
        check("de_before_data", 16'(de_o), 16'h0);
        tx(TOK0);
        check("de_data", 16'(de_o), 16'h1);
        check("data_5a", 16'(data_o), 16'h5A);
        repeat (4) tx(TOK0);
    endtask

    task automatic timeout_drop(input int unsigned off);
        for (int i = 0; i < 15; i++) send_data(i % 7, 1'b1);
        send_data(0, 1'b0);
        send_data(1, 1'b0);
        check("still_locked", 16'(locked_o), 16'h1);
        check("offset_held", 16'(offset_o), 16'(off));
        send_data(2, 1'b0);
        check("drop_locked", 16'(locked_o), 16'h0);
        check("drop_offset", 16'(offset_o), 16'((off == 9) ? 0 : off + 1));
        check("drop_de", 16'(de_o), 16'h0);
        check("drop_data", 16'(data_o), 16'h0);
        check("drop_ctrl", 16'(ctrl_o), 16'h0);
    endtask

    initial begin
        logic [9:0] seq [6];
        logic [1:0] cseq [6];
        logic [1:0] h1, h2;

        fork
            forever begin
                @(negedge clk);
                if (de_o === 1'b1) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL sb_extra: got data %0h with no expected byte at %0t", data_o, $time);
                    end else begin
                        check("sb_data", 16'(data_o), 16'(sb.pop_front()));
                    end
                end
            end
            forever begin
                @(negedge clk);
                if (32'(offset_o) != off_last) begin
                    check("offset_step", 16'(offset_o), 16'((off_last == 9) ? 0 : off_last + 1));
                    off_last = 32'(offset_o);
                    off_steps++;
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check("init_data", 16'(data_o), 16'h0);
        check("init_de", 16'(de_o), 16'h0);
        check("init_ctrl", 16'(ctrl_o), 16'h0);
        check("init_locked", 16'(locked_o), 16'h0);
        check("init_offset", 16'(offset_o), 16'h0);
        rst = 1'b0;

        aligned_lock();

        seq  = '{TOK1, TOK2, TOK3, TOK0, TOK0, TOK0};
        cseq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0};
        h1 = 2'd0;
        h2 = 2'd0;
        for (int i = 0; i < 6; i++) begin
            tx(seq[i]);
            check("ctrl_seq", 16'(ctrl_o), 16'(h2));
            check("ctrl_de", 16'(de_o), 16'h0);
            h2 = h1;
            h1 = cseq[i];
        end

        timeout_drop(0);

        pulse_reset();
        set_shift(3);
        repeat (80) tx(TOK0);
        check("shift3_locked", 16'(locked_o), 16'h1);
        check("shift3_offset", 16'(offset_o), 16'h3);
        check("shift3_steps", 16'(off_steps), 16'h3);
        for (int line = 0; line < 2; line++) begin
            for (int k = 0; k < 5; k++) send_data((line * 5 + k) % 7, 1'b1);
            repeat (20) tx(TOK0);
        end
        check("shift3_hold", 16'(locked_o), 16'h1);

        pulse_reset();
        aligned_lock();

        pulse_reset();
        set_shift(9);
        repeat (200) tx(TOK0);
        check("shift9_locked", 16'(locked_o), 16'h1);
        check("shift9_offset", 16'(offset_o), 16'h9);
        check("shift9_steps", 16'(off_steps), 16'h9);
        timeout_drop(9);
        check("wrap_steps", 16'(off_steps), 16'hA);

        repeat (4) tx(TOK0);
        check("sb_drained", 16'(sb.size()), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
